// File: rtl/spi_master_arbiter_if.sv
// Client-side and spi_master-side signal bundle for spi_master_arbiter.
// master: arbiter view; slave: the clients plus spi_master view.
interface spi_master_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
);
  logic [NUM_REQ-1:0]            cl_req;
  logic [NUM_REQ-1:0]            cl_dir;
  logic [NUM_REQ*LEN_WIDTH-1:0]  cl_len;
  logic [NUM_REQ*DATA_WIDTH-1:0] cl_data;
  logic [NUM_REQ-1:0]            cl_ack;
  logic [NUM_REQ-1:0]            cl_done;
  logic                          m_req;
  logic                          m_dir;
  logic [LEN_WIDTH-1:0]          m_len;
  logic [DATA_WIDTH-1:0]         m_data;
  logic                          m_ack;
  logic                          m_ss;

  modport master (
    input  cl_req, cl_dir, cl_len, cl_data, m_ack, m_ss,
    output cl_ack, cl_done, m_req, m_dir, m_len, m_data
  );

  modport slave (
    output cl_req, cl_dir, cl_len, cl_data, m_ack, m_ss,
    input  cl_ack, cl_done, m_req, m_dir, m_len, m_data
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one spi_master among NUM_REQ clients.
// Optional watchdog: define SPI_ARB_WATCHDOG_EN to abort stuck transfers after TIMEOUT_CYCLES.
module spi_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int LEN_WIDTH      = 4,
  parameter int TO_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_master_arbiter_if.master bus,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        winner;
  logic                   ss_seen;
  logic                   grant, finish, timeout;
  logic [NUM_REQ-1:0]     ack_q, done_q;
  logic                   m_req_q, m_dir_q;
  logic [LEN_WIDTH-1:0]   m_len_q;
  logic [DATA_WIDTH-1:0]  m_data_q;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 ||
      $clog2(TIMEOUT_CYCLES) > TO_WIDTH) begin : g_cfg_check
    $error("spi_master_arbiter: illegal parameter combination");
  end

  // First requester strictly after ptr, wrapping, so the last winner has lowest priority.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] win;
    logic            found;
    int              idx;
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        win   = ID_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign winner = rr_pick(bus.cl_req, rr_ptr);

`ifdef SPI_ARB_WATCHDOG_EN
  logic [TO_WIDTH-1:0] wd_cnt;
  logic                err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= timeout;
      if (grant)                 wd_cnt <= '0;
      else if (state_q != IDLE)  wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout = (state_q != IDLE) && (wd_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: if (|bus.cl_req) begin
        grant   = 1'b1;
        state_d = REQ;
      end
      REQ:  if (bus.m_ack) state_d = XFER;
      XFER: if (ss_seen && !bus.m_ss) begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // An aborted transfer never reports done to its client.
    if (timeout) begin
      finish  = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= '0;
      done_q   <= '0;
      m_req_q  <= 1'b0;
      m_dir_q  <= 1'b0;
      m_len_q  <= '0;
      m_data_q <= '0;
      grant_id <= '0;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
      ss_seen  <= 1'b0;
    end else begin
      ack_q  <= '0;
      done_q <= '0;
      if (grant) begin
        ack_q[winner] <= 1'b1;
        grant_id      <= winner;
        rr_ptr        <= winner;
        m_req_q       <= 1'b1;
        m_dir_q       <= bus.cl_dir[winner];
        m_len_q       <= bus.cl_len[int'(winner)*LEN_WIDTH +: LEN_WIDTH];
        m_data_q      <= bus.cl_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
        ss_seen       <= 1'b0;
      end
      // The master loads on the same edge it acks, so req drops only after that edge.
      if (state_q == REQ && bus.m_ack) m_req_q <= 1'b0;
      if (state_q == XFER && bus.m_ss) ss_seen <= 1'b1;
      if (finish)                      done_q[grant_id] <= 1'b1;
      if (timeout)                     m_req_q <= 1'b0;
    end
  end

  assign bus.cl_ack  = ack_q;
  assign bus.cl_done = done_q;
  assign bus.m_req   = m_req_q;
  assign bus.m_dir   = m_dir_q;
  assign bus.m_len   = m_len_q;
  assign bus.m_data  = m_data_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: directed scenarios plus random client traffic
// checked against a transaction-level round-robin reference and a simple spi_master model.
module tb_spi_master_arbiter;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int LW  = 4;
  localparam int TOW = 16;
  localparam int TO  = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant_id;
  logic       busy, err;

  spi_master_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  spi_master_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TO_WIDTH(TOW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // spi_master model: acks one cycle after seeing req, then holds ss for ss_len cycles.
  int mst, ss_cnt;
  int ss_len = 16;
  bit no_ack = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst <= 0; ss_cnt <= 0; bus.m_ack <= 1'b0; bus.m_ss <= 1'b0;
    end else begin
      case (mst)
        0: if (bus.m_req && !no_ack) begin bus.m_ack <= 1'b1; mst <= 2; end
        2: begin bus.m_ack <= 1'b0; bus.m_ss <= 1'b1; ss_cnt <= ss_len - 1; mst <= 3; end
        3: if (ss_cnt == 0) begin bus.m_ss <= 1'b0; mst <= 0; end
           else ss_cnt <= ss_cnt - 1;
        default: mst <= 0;
      endcase
    end
  end

  int total = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference: transaction-level view of grants and completions.
  int            ref_last = N - 1;
  bit            outstanding = 1'b0;
  int            cur = 0;
  logic [DW-1:0] exp_data;
  logic [LW-1:0] exp_len;
  logic          exp_dir;
  int            grant_q[$];
  int            n_dones = 0;

  // Requester closest after the previous winner in cyclic distance.
  function automatic int ref_winner(input logic [N-1:0] req, input int last);
    int best, best_dist;
    best = -1; best_dist = N;
    for (int i = 0; i < N; i++) begin
      int d;
      d = (i - last - 1 + 2 * N) % N;
      if (req[i] && d < best_dist) begin best_dist = d; best = i; end
    end
    return best;
  endfunction

  task automatic observe();
    int idx;
    logic [N-1:0] one;
    one = 1;
    if (bus.cl_ack !== '0) begin
      idx = -1;
      for (int i = 0; i < N; i++) if (bus.cl_ack[i]) idx = i;
      chk("ack_onehot", $countones(bus.cl_ack), 1);
      chk("ack_rr_order", idx, ref_winner(bus.cl_req, ref_last));
      chk("ack_while_busy", outstanding, 0);
      chk("grant_id", grant_id, idx);
      chk("cap_data", bus.m_data, bus.cl_data[idx*DW +: DW]);
      chk("cap_len", bus.m_len, bus.cl_len[idx*LW +: LW]);
      chk("cap_dir", bus.m_dir, bus.cl_dir[idx]);
      ref_last = idx; cur = idx; outstanding = 1'b1;
      exp_data = bus.cl_data[idx*DW +: DW];
      exp_len  = bus.cl_len[idx*LW +: LW];
      exp_dir  = bus.cl_dir[idx];
      grant_q.push_back(idx);
    end else if (outstanding) begin
      chk("hold_dir_len_data", {bus.m_dir, bus.m_len, bus.m_data}, {exp_dir, exp_len, exp_data});
    end
    if (bus.cl_done !== '0) begin
      chk("done_expected", outstanding, 1);
      chk("done_client", bus.cl_done, one << cur);
      outstanding = 1'b0;
      n_dones++;
    end
    if (err === 1'b1) outstanding = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.cl_req = '0;
    #1;
    outstanding = 1'b0;
    ref_last = N - 1;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic run_until_grant(input int bound, output int idx);
    int start, n;
    start = grant_q.size(); n = 0; idx = -1;
    while (grant_q.size() == start && n < bound) begin tick(); n++; end
    chk("grant_within_bound", grant_q.size() > start, 1);
    if (grant_q.size() > start) idx = grant_q[$];
  endtask

  task automatic run_until_done(input int bound);
    int start, n;
    start = n_dones; n = 0;
    while (n_dones == start && n < bound) begin tick(); n++; end
    chk("done_within_bound", n_dones > start, 1);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((busy || outstanding) && n < bound) begin tick(); n++; end
    chk("idle_within_bound", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int idx, n, raised, served;
    bit early;
    logic [DW-1:0] cap;

    bus.cl_req = '0; bus.cl_dir = '0; bus.cl_len = '0; bus.cl_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cl_ack", bus.cl_ack, 0);
    chk("rst_cl_done", bus.cl_done, 0);
    chk("rst_m_req", bus.m_req, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_m_len_dir", {bus.m_len, bus.m_dir}, 0);
    chk("rst_grant_busy_err", {grant_id, busy, err}, 0);
    rst_n = 1'b1;
    tick();

    // Single client 2 transfer with exact latency
    bus.cl_data[2*DW +: DW] = 8'hA5;
    bus.cl_len[2*LW +: LW]  = 4'd8;
    bus.cl_dir[2]           = 1'b1;
    bus.cl_req              = 4'b0100;
    tick();
    chk("t1_ack", bus.cl_ack, 4'b0100);
    chk("t1_req_busy", {bus.m_req, busy, bus.m_ack}, 3'b110);
    chk("t1_data", bus.m_data, 8'hA5);
    bus.cl_req = '0;
    tick();
    chk("t1_ack_cycle", {bus.m_req, bus.m_ack, bus.cl_ack}, {2'b11, 4'b0000});
    tick();
    chk("t1_req_dropped", {bus.m_req, bus.m_ss, busy}, 3'b011);
    n = 0;
    while (bus.m_ss === 1'b1 && n < 64) begin tick(); n++; end
    chk("t1_ss_fell", bus.m_ss, 0);
    chk("t1_no_early_done", {bus.cl_done, busy}, {4'b0000, 1'b1});
    chk("t1_data_xfer", bus.m_data, 8'hA5);
    tick();
    chk("t1_done", bus.cl_done, 4'b0100);
    chk("t1_idle", busy, 0);
    tick();
    chk("t1_done_pulse", {bus.cl_done, busy}, 0);

    // All clients held: strict rotation from reset
    do_reset();
    ss_len = 2;
    grant_q.delete();
    for (int i = 0; i < N; i++) begin
      bus.cl_data[i*DW +: DW] = DW'(8'h10 + i);
      bus.cl_len[i*LW +: LW]  = LW'(i + 1);
      bus.cl_dir[i]           = i[0];
    end
    bus.cl_req = 4'b1111;
    n = 0;
    while (grant_q.size() < 5 && n < 400) begin tick(); n++; end
    bus.cl_req = '0;
    chk("t2_five_grants", grant_q.size(), 5);
    if (grant_q.size() >= 5) begin
      chk("t2_g0", grant_q[0], 0);
      chk("t2_g1", grant_q[1], 1);
      chk("t2_g2", grant_q[2], 2);
      chk("t2_g3", grant_q[3], 3);
      chk("t2_g4", grant_q[4], 0);
    end
    wait_idle(100);

    // Client 1 mid-transfer; 3 and 0 queue, 3 wins; client 0 data changes after its ack
    ss_len = 4;
    bus.cl_data[1*DW +: DW] = 8'h3C;
    bus.cl_req = 4'b0010;
    tick();
    chk("t3_first", bus.cl_ack, 4'b0010);
    bus.cl_req = '0;
    tick();
    tick();
    chk("t3_in_xfer", {busy, bus.m_req}, 2'b10);
    bus.cl_data[0*DW +: DW] = 8'h5A;
    bus.cl_data[3*DW +: DW] = 8'hC3;
    bus.cl_req = 4'b1001;
    run_until_grant(100, idx);
    chk("t3_three_before_zero", idx, 3);
    bus.cl_req[3] = 1'b0;
    run_until_grant(100, idx);
    chk("t3_then_zero", idx, 0);
    bus.cl_req[0] = 1'b0;
    cap = bus.m_data;
    bus.cl_data[0*DW +: DW] = ~cap;
    run_until_done(100);
    chk("t6_data_kept", bus.m_data, 8'h5A);
    wait_idle(100);

    // Reset in XFER, then clean grant to client 3
    ss_len = 16;
    bus.cl_data[2*DW +: DW] = 8'h77;
    bus.cl_req = 4'b0100;
    tick();
    bus.cl_req = '0;
    tick();
    tick();
    chk("t4_in_xfer", {busy, bus.m_ss}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("t4_async_clear", {bus.m_req, busy, bus.cl_ack, bus.cl_done}, 0);
    chk("t4_async_data", {bus.m_data, grant_id}, 0);
    outstanding = 1'b0;
    ref_last = N - 1;
    repeat (3) tick();
    rst_n = 1'b1;
    bus.cl_data[3*DW +: DW] = 8'hE1;
    bus.cl_req = 4'b1000;
    tick();
    chk("t4_regrant", {bus.cl_ack, grant_id}, {4'b1000, 2'd3});
    bus.cl_req = '0;
    run_until_done(100);
    chk("t4_done", bus.cl_done, 4'b1000);
    wait_idle(100);

    // Master never acks
    no_ack = 1'b1;
    bus.cl_req = 4'b0010;
    tick();
    bus.cl_req = '0;
`ifdef SPI_ARB_WATCHDOG_EN
    early = 1'b0;
    repeat (TO - 1) begin tick(); if (err) early = 1'b1; end
    chk("t5_no_early_err", early, 0);
    tick();
    chk("t5_err", err, 1);
    chk("t5_idle", {busy, bus.m_req, bus.cl_done}, 0);
    tick();
    chk("t5_err_pulse", err, 0);
    repeat (4) tick();
    no_ack = 1'b0;
`else
    early = 1'b0;
    repeat (TO + 8) begin tick(); if (err) early = 1'b1; end
    chk("t5_no_err", early, 0);
    chk("t5_waiting", {busy, bus.m_req}, 2'b11);
    no_ack = 1'b0;
    do_reset();
`endif

    // Random traffic against the reference
    raised = 0; served = 0;
    for (int c = 0; c < 2500; c++) begin
      tick();
      if ($urandom_range(0, 3) == 0) ss_len = $urandom_range(1, 6);
      for (int i = 0; i < N; i++) begin
        if (bus.cl_ack[i]) begin
          bus.cl_req[i] = 1'b0;
          served++;
        end else if (!bus.cl_req[i] && $urandom_range(0, 7) == 0) begin
          bus.cl_data[i*DW +: DW] = DW'($urandom);
          bus.cl_len[i*LW +: LW]  = LW'($urandom);
          bus.cl_dir[i]           = 1'($urandom);
          bus.cl_req[i]           = 1'b1;
          raised++;
        end
      end
    end
    n = 0;
    while ((bus.cl_req != '0 || busy || outstanding) && n < 1000) begin
      tick();
      for (int i = 0; i < N; i++)
        if (bus.cl_ack[i]) begin bus.cl_req[i] = 1'b0; served++; end
      n++;
    end
    chk("rand_drained", {bus.cl_req, busy}, 0);
    chk("rand_all_served", served, raised);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
